v_hier_subarr: RTL and testbench

Parametrised multi-channel successor to the fixed 4-bit hierarchy sub-block. It moves a CHANNELS-wide vector through a DEPTH-stage elastic pipeline with valid/ready handshakes and a per-beat transform mode. It also counts completed output transfers. It sits at the same level of the hierarchy as the 4-bit block and is built from one repeated per-stage cell, so the hierarchy parser sees parameter overrides, generate-instanced cells and positional/named connections.

---
 rtl/v_hier_pkg.sv | 40 ++++
 rtl/v_hier_subcell.sv | 33 +++
 rtl/v_hier_subarr.sv | 83 ++++++++
 tb/tb_v_hier_subarr.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/v_hier_pkg.sv
// Shared definitions for the v_hier hierarchy blocks: beat transform modes
// and a width-generic transform helper.
package v_hier_pkg;

   typedef enum logic [1:0] {
      MODE_PASS  = 2'd0,
      MODE_INV   = 2'd1,
      MODE_REV   = 2'd2,
      MODE_FORCE = 2'd3
   } mode_t;

   localparam int unsigned MAX_W = 64;
   localparam int unsigned IDX_W = $clog2(MAX_W);

   // Operates on the low w bits of a MAX_W container; bits at and above w
   // are don't-care and must be dropped by the caller.
   function automatic logic [MAX_W-1:0] apply_mode(input logic [MAX_W-1:0] v,
                                                   input int unsigned      w,
                                                   input mode_t            m);
      logic [MAX_W-1:0] r;
      logic [IDX_W-1:0] src;
      r = '0;
      unique case (m)
         MODE_PASS:  r = v;
         MODE_INV:   r = ~v;
         MODE_REV: begin
            for (int unsigned i = 0; i < MAX_W; i++) begin
               if (i < w) begin
                  src = IDX_W'(w - 1 - i);
                  r[IDX_W'(i)] = v[src];
               end
            end
         end
         MODE_FORCE: r[0] = 1'b1;
         default:    r = v;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/v_hier_subcell.sv
// One elastic pipeline stage: a valid bit plus WIDTH data bits, with a
// combinational ready pass-through so a full chain still streams.
module v_hier_subcell
   import v_hier_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   input  logic             d_valid,
   output logic             d_ready,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   input  logic             q_ready
);

   assign d_ready = !q_valid || q_ready;

   // Data only moves with a real beat so an empty stage keeps its last value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_valid <= 1'b0;
         q       <= '0;
      end else if (d_ready) begin
         q_valid <= d_valid;
         if (d_valid) begin
            q <= d;
         end
      end
   end

endmodule

// File: rtl/v_hier_subarr.sv
// Multi-channel elastic pipeline of DEPTH v_hier_subcell stages with a
// per-beat entry transform and an output-transfer counter.
module v_hier_subarr
   import v_hier_pkg::*;
#(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned COUNT_W  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] avec,
   input  logic [1:0]          mode,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [CHANNELS-1:0] qvec,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [COUNT_W-1:0]  xfer_count
);

   logic [MAX_W-1:0]    wide_in;
   logic [MAX_W-1:0]    wide_out;
   logic [CHANNELS-1:0] entry_data;

   // Index k is the input side of stage k; index DEPTH is the block output.
   logic [CHANNELS-1:0] sd [DEPTH+1];
   logic                sv [DEPTH+1];
   logic                sr [DEPTH+1];

   always_comb begin
      wide_in                 = '0;
      wide_in[CHANNELS-1:0]   = avec;
      wide_out                = apply_mode(wide_in, CHANNELS, mode_t'(mode));
      entry_data              = wide_out[CHANNELS-1:0];
   end

   if (CHANNELS < MAX_W) begin : g_spare
      logic unused_hi;
      assign unused_hi = ^wide_out[MAX_W-1:CHANNELS];
   end

   assign sd[0]     = entry_data;
   assign sv[0]     = in_valid;
   assign sr[DEPTH] = out_ready;
   assign in_ready  = sr[0];
   assign qvec      = sd[DEPTH];
   assign out_valid = sv[DEPTH];

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_head
         v_hier_subcell #(
            .WIDTH (CHANNELS)
         ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .d       (sd[0]),
            .d_valid (sv[0]),
            .d_ready (sr[0]),
            .q       (sd[1]),
            .q_valid (sv[1]),
            .q_ready (sr[1])
         );
      end else begin : g_tail
         v_hier_subcell #(
            .WIDTH (CHANNELS)
         ) u_cell (
            clk, rst,
            sd[k], sv[k], sr[k],
            sd[k+1], sv[k+1], sr[k+1]
         );
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xfer_count <= '0;
      end else if (out_valid && out_ready) begin
         xfer_count <= xfer_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_v_hier_subarr.sv
// Scoreboard bench: directed vectors on a 4x2 instance, random handshakes
// on 8x1 and 1x4 instances checked against a FIFO of expected beats.
module tb_v_hier_subarr;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] xf(input logic [7:0] v, input logic [1:0] m, input int w);
      logic [7:0] mask;
      logic [7:0] r;
      mask = 8'((1 << w) - 1);
      r = 8'd0;
      case (m)
         2'd0: r = v;
         2'd1: r = ~v;
         2'd2: for (int i = 0; i < w; i++) r[i] = v[w-1-i];
         default: r = 8'd1;
      endcase
      return r & mask;
   endfunction

   // ---------------- instance A: CHANNELS=4, DEPTH=2, COUNT_W=4
   logic       a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [3:0] a_avec, a_qvec, a_xfer;
   logic [1:0] a_mode;

   v_hier_subarr #(.CHANNELS(4), .DEPTH(2), .COUNT_W(4)) u_a (
      .clk(clk), .rst(a_rst), .avec(a_avec), .mode(a_mode),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .qvec(a_qvec),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .xfer_count(a_xfer));

   typedef struct { logic [3:0] d; int acc; } ent_t;
   ent_t qa[$];
   bit   lat_chk = 1'b1;

   always @(negedge clk) begin
      ent_t e;
      if (!a_rst && a_out_valid && a_out_ready) begin
         if (qa.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL a_unexpected: got beat %0h expected none", a_qvec);
         end else begin
            e = qa.pop_front();
            chk("a_qvec", 64'(a_qvec), 64'(e.d));
            if (lat_chk) chk("a_latency", 64'(cyc - e.acc), 64'd2);
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic send_a(input logic [3:0] v, input logic [1:0] m, input logic [3:0] exp);
      ent_t e;
      bit ok;
      ok = 1'b0;
      a_avec = v; a_mode = m; a_in_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (a_in_ready) ok = 1'b1;
         else step();
      end
      if (ok) begin
         e.d = exp; e.acc = cyc;
         qa.push_back(e);
      end else begin
         n_checks++; n_fail++;
         $display("FAIL a_accept_timeout: got in_ready 0 expected 1 within 50 cycles");
      end
      step();
      a_in_valid = 1'b0;
   endtask

   task automatic idle_a(input int n);
      a_in_valid = 1'b0; a_avec = 4'hE; a_mode = 2'd1;
      repeat (n) step();
   endtask

   // ---------------- instances B (8x1) and C (1x4), random traffic
   logic       bc_rst;
   logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [7:0] b_avec, b_qvec, b_xfer;
   logic [1:0] b_mode;
   logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready;
   logic [0:0] c_avec, c_qvec;
   logic [7:0] c_xfer;
   logic [1:0] c_mode;

   v_hier_subarr #(.CHANNELS(8), .DEPTH(1), .COUNT_W(8)) u_b (
      .clk(clk), .rst(bc_rst), .avec(b_avec), .mode(b_mode),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .qvec(b_qvec),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .xfer_count(b_xfer));

   v_hier_subarr #(.CHANNELS(1), .DEPTH(4), .COUNT_W(8)) u_c (
      .clk(clk), .rst(bc_rst), .avec(c_avec), .mode(c_mode),
      .in_valid(c_in_valid), .in_ready(c_in_ready), .qvec(c_qvec),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .xfer_count(c_xfer));

   logic [7:0] qb[$];
   logic [7:0] qc[$];
   int nb_hs = 0;
   int nc_hs = 0;

   always @(negedge clk) begin
      logic [7:0] e;
      if (!bc_rst && b_out_valid && b_out_ready) begin
         nb_hs++;
         if (qb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL b_unexpected: got beat %0h expected none", b_qvec);
         end else begin
            e = qb.pop_front();
            chk("b_qvec", 64'(b_qvec), 64'(e));
         end
      end
   end

   always @(negedge clk) begin
      logic [7:0] e;
      if (!bc_rst && c_out_valid && c_out_ready) begin
         nc_hs++;
         if (qc.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL c_unexpected: got beat %0h expected none", c_qvec);
         end else begin
            e = qc.pop_front();
            chk("c_qvec", 64'(c_qvec), 64'(e));
         end
      end
   end

   task automatic rnd_b();
      repeat (300) begin
         b_in_valid  = 1'($urandom_range(0, 1));
         b_out_ready = ($urandom_range(0, 3) != 0);
         b_avec      = 8'($urandom);
         b_mode      = 2'($urandom_range(0, 3));
         @(negedge clk);
         if (b_in_valid && b_in_ready) qb.push_back(xf(b_avec, b_mode, 8));
         step();
      end
      b_in_valid = 1'b0; b_out_ready = 1'b1;
      repeat (6) step();
      chk("b_drained", 64'(qb.size()), 64'd0);
      chk("b_xfer", 64'(b_xfer), 64'(nb_hs % 256));
   endtask

   task automatic rnd_c();
      repeat (300) begin
         c_in_valid  = 1'($urandom_range(0, 1));
         c_out_ready = ($urandom_range(0, 2) != 0);
         c_avec      = 1'($urandom_range(0, 1));
         c_mode      = 2'($urandom_range(0, 3));
         @(negedge clk);
         if (c_in_valid && c_in_ready) qc.push_back(xf({7'd0, c_avec}, c_mode, 1));
         step();
      end
      c_in_valid = 1'b0; c_out_ready = 1'b1;
      repeat (10) step();
      chk("c_drained", 64'(qc.size()), 64'd0);
      chk("c_xfer", 64'(c_xfer), 64'(nc_hs % 256));
   endtask

   initial begin
      a_rst = 1'b1; a_in_valid = 1'b0; a_avec = 4'h0; a_mode = 2'd0; a_out_ready = 1'b1;
      bc_rst = 1'b1;
      b_in_valid = 1'b0; b_out_ready = 1'b1; b_avec = 8'h00; b_mode = 2'd0;
      c_in_valid = 1'b0; c_out_ready = 1'b1; c_avec = 1'b0; c_mode = 2'd0;
      #2;
      chk("rst_in_ready",  64'(a_in_ready),  64'd1);
      chk("rst_out_valid", 64'(a_out_valid), 64'd0);
      chk("rst_qvec",      64'(a_qvec),      64'd0);
      chk("rst_xfer",      64'(a_xfer),      64'd0);
      step();
      a_rst = 1'b0; bc_rst = 1'b0;

      // back-to-back pass-through, latency DEPTH edges
      send_a(4'h1, 2'd0, 4'h1);
      send_a(4'h2, 2'd0, 4'h2);
      send_a(4'h3, 2'd0, 4'h3);
      idle_a(4);
      chk("t1_xfer", 64'(a_xfer), 64'd3);
      chk("t1_empty", 64'(qa.size()), 64'd0);

      // transform modes, mode changing while earlier beats are in flight
      send_a(4'hA, 2'd1, 4'h5);
      send_a(4'h1, 2'd2, 4'h8);
      send_a(4'hF, 2'd3, 4'h1);
      send_a(4'hC, 2'd2, 4'h3);
      send_a(4'h6, 2'd1, 4'h9);
      idle_a(4);
      chk("modes_xfer", 64'(a_xfer), 64'd8);

      // backpressure: fill, hold beat 3, then stream without gaps
      lat_chk = 1'b0;
      a_out_ready = 1'b0;
      send_a(4'h1, 2'd0, 4'h1);
      send_a(4'h2, 2'd0, 4'h2);
      a_avec = 4'h3; a_mode = 2'd0; a_in_valid = 1'b1;
      @(negedge clk);
      chk("full_in_ready", 64'(a_in_ready), 64'd0);
      chk("full_out_valid", 64'(a_out_valid), 64'd1);
      step();
      a_out_ready = 1'b1;
      @(negedge clk);
      chk("full_flow_in_ready", 64'(a_in_ready), 64'd1);
      qa.push_back('{d: 4'h3, acc: cyc});
      step();
      a_in_valid = 1'b0;
      @(negedge clk);
      chk("nogap_1", 64'(a_out_valid), 64'd1);
      step();
      @(negedge clk);
      chk("nogap_2", 64'(a_out_valid), 64'd1);
      idle_a(3);
      chk("bp_xfer", 64'(a_xfer), 64'd11);
      chk("bp_empty", 64'(qa.size()), 64'd0);

      // asynchronous reset with two beats in flight
      a_out_ready = 1'b0;
      send_a(4'h4, 2'd0, 4'h4);
      send_a(4'h5, 2'd0, 4'h5);
      a_rst = 1'b1;
      #1;
      chk("arst_out_valid", 64'(a_out_valid), 64'd0);
      chk("arst_qvec",      64'(a_qvec),      64'd0);
      chk("arst_xfer",      64'(a_xfer),      64'd0);
      chk("arst_in_ready",  64'(a_in_ready),  64'd1);
      qa.delete();
      @(negedge clk);
      a_rst = 1'b0; a_out_ready = 1'b1;
      step();
      lat_chk = 1'b1;
      send_a(4'h7, 2'd0, 4'h7);
      idle_a(4);
      chk("post_rst_xfer", 64'(a_xfer), 64'd1);
      chk("post_rst_empty", 64'(qa.size()), 64'd0);

      // counter wrap: 17 handshakes since reset on a 4-bit counter
      for (int i = 0; i < 16; i++) send_a(4'(i), 2'd0, 4'(i));
      idle_a(4);
      chk("wrap_xfer", 64'(a_xfer), 64'd1);

      fork
         rnd_b();
         rnd_c();
      join

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
